id_ex_operand_stage: RTL and testbench

//  Decode-stage operand capture directly downstream of the 32x32 register file. Drives its read

---
 rtl/id_ex_operand_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand capture: register-file addressing, optional writeback bypass (WB_BYPASS_EN),
// load-use hazard detection and the ID/EX pipeline register with a saturating bubble counter.
module id_ex_operand_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [DW-1:0]   id_instr,
    input  logic [DW-1:0]   id_pc_plus4,
    output logic [AW-1:0]   rf_rd_addr1,
    output logic [AW-1:0]   rf_rd_addr2,
    input  logic [DW-1:0]   rf_rd_data1,
    input  logic [DW-1:0]   rf_rd_data2,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [DW-1:0]   wb_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            id_stall,
    output logic            ex_valid,
    output logic [DW-1:0]   ex_rs_data,
    output logic [DW-1:0]   ex_rt_data,
    output logic [DW-1:0]   ex_imm,
    output logic [AW-1:0]   ex_rs,
    output logic [AW-1:0]   ex_rt,
    output logic [AW-1:0]   ex_rd,
    output logic [5:0]      ex_opcode,
    output logic [5:0]      ex_funct,
    output logic            ex_mem_read,
    output logic [DW-1:0]   ex_pc_plus4,
    output logic [CNTW-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    logic [5:0]           id_opcode;
    logic [AW-1:0]        id_rs;
    logic [AW-1:0]        id_rt;
    logic [AW-1:0]        id_rd;
    logic [DW-1:0]        id_imm;
    logic                 rt_used;
    logic                 hazard;
    logic                 hold;

    logic [1:0][AW-1:0]   src_addr;
    logic [1:0][DW-1:0]   rf_data;
    logic [1:0]           byp_hit;
    logic [1:0][DW-1:0]   opnd;

    assign id_opcode = id_instr[31:26];
    assign id_rs     = id_instr[25:21];
    assign id_rt     = id_instr[20:16];
    assign id_rd     = id_instr[15:11];
    assign id_imm    = {{(DW-16){id_instr[15]}}, id_instr[15:0]};

    assign rf_rd_addr1 = id_rs;
    assign rf_rd_addr2 = id_rt;

    assign src_addr[0] = id_rs;
    assign src_addr[1] = id_rt;
    assign rf_data[0]  = rf_rd_data1;
    assign rf_data[1]  = rf_rd_data2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
`ifdef WB_BYPASS_EN
            assign byp_hit[gi] = wb_we && (wb_addr == src_addr[gi]);
`else
            assign byp_hit[gi] = 1'b0;
`endif
            // Register 0 is hard-wired to zero even if writeback targets it.
            assign opnd[gi] = (src_addr[gi] == '0) ? '0 :
                              byp_hit[gi]          ? wb_data : rf_data[gi];
        end
    endgenerate

`ifndef WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

    assign rt_used = (id_opcode == OP_RTYPE) || (id_opcode == OP_SW) ||
                     (id_opcode == OP_BEQ)   || (id_opcode == OP_BNE);

    assign hazard = ex_valid && ex_mem_read && (ex_rt != '0) && id_valid &&
                    ((ex_rt == id_rs) || (rt_used && (ex_rt == id_rt)));

    assign hold     = ex_valid && !ex_ready;
    assign id_stall = hazard || hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct    <= '0;
            ex_mem_read <= 1'b0;
            ex_pc_plus4 <= '0;
            stall_cnt   <= '0;
        end else if (flush) begin
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
        end else if (hold) begin
            ex_valid    <= ex_valid;
        end else if (hazard) begin
            // One-cycle bubble; ex_mem_read drops so the hazard clears itself.
            ex_valid    <= 1'b0;
            ex_mem_read <= 1'b0;
            if (stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end else begin
            ex_valid    <= id_valid;
            ex_rs_data  <= opnd[0];
            ex_rt_data  <= opnd[1];
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_opcode   <= id_opcode;
            ex_funct    <= id_instr[5:0];
            ex_mem_read <= id_valid && (id_opcode == OP_LW);
            ex_pc_plus4 <= id_pc_plus4;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomised bench for id_ex_operand_stage against an instruction-level model of the ID/EX
// register, plus directed scenarios with literal expectations.
module tb_id_ex_operand_stage;

    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst, id_valid, wb_we, flush, ex_ready;
    logic [31:0]     id_instr, id_pc_plus4, rf_rd_data1, rf_rd_data2, wb_data;
    logic [4:0]      wb_addr, rf_rd_addr1, rf_rd_addr2;
    logic            id_stall, ex_valid, ex_mem_read;
    logic [31:0]     ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4;
    logic [4:0]      ex_rs, ex_rt, ex_rd;
    logic [5:0]      ex_opcode, ex_funct;
    logic [CNTW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // Model of the ID/EX entry as the execute stage should see it.
    logic        m_valid, m_mr;
    logic [31:0] m_rs_data, m_rt_data, m_imm, m_pc;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic [5:0]  m_op, m_funct;
    int          m_cnt;

    id_ex_operand_stage #(.DW(32), .AW(5), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
        .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush), .ex_ready(ex_ready),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_mem_read(ex_mem_read), .ex_pc_plus4(ex_pc_plus4), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rfd,
                                            input logic we, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return rfd;
    endfunction

    // Apply one cycle of inputs, check the combinational outputs, compute the model's next entry.
    task automatic set_in(input logic r, v, input logic [31:0] instr, pc, d1, d2,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic fl, rdy);
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic rtu, hz, hold;
        rst = r; id_valid = v; id_instr = instr; id_pc_plus4 = pc;
        rf_rd_data1 = d1; rf_rd_data2 = d2; wb_we = we; wb_addr = wa; wb_data = wd;
        flush = fl; ex_ready = rdy;
        #1;
        op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16];
        rtu  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
        hz   = m_mr && m_valid && m_rt != 0 && v && (m_rt == rs || (rtu && m_rt == rt));
        hold = m_valid && !rdy;
        chk("rf_rd_addr1", {27'd0, rf_rd_addr1}, {27'd0, rs});
        chk("rf_rd_addr2", {27'd0, rf_rd_addr2}, {27'd0, rt});
        chk("id_stall", {31'd0, id_stall}, {31'd0, hz || hold});
        if (r) begin
            m_valid = 0; m_mr = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_pc = 0;
            m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0; m_funct = 0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 0; m_mr = 0;
        end else if (hold) begin
            m_valid = m_valid;
        end else if (hz) begin
            m_valid = 0; m_mr = 0;
            m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
        end else begin
            m_valid   = v;
            m_mr      = v && (op == 6'h23);
            m_rs_data = operand(rs, d1, we, wa, wd);
            m_rt_data = operand(rt, d2, we, wa, wd);
            m_imm     = {{16{instr[15]}}, instr[15:0]};
            m_pc      = pc;
            m_rs = rs; m_rt = rt; m_rd = instr[15:11];
            m_op = op; m_funct = instr[5:0];
        end
    endtask

    // Cross the capture edge and compare the registered outputs with the model.
    task automatic advance();
        @(negedge clk);
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mr});
        chk("stall_cnt", {28'd0, stall_cnt}, m_cnt[31:0]);
        if (m_valid) begin
            chk("ex_rs_data", ex_rs_data, m_rs_data);
            chk("ex_rt_data", ex_rt_data, m_rt_data);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_pc_plus4", ex_pc_plus4, m_pc);
            chk("ex_rs", {27'd0, ex_rs}, {27'd0, m_rs});
            chk("ex_rt", {27'd0, ex_rt}, {27'd0, m_rt});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_opcode", {26'd0, ex_opcode}, {26'd0, m_op});
            chk("ex_funct", {26'd0, ex_funct}, {26'd0, m_funct});
        end
    endtask

    initial begin
        logic [31:0] lw9, add9, instr;
        logic [5:0]  ops [6];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08};
        lw9  = i_type(6'h23, 5'd0, 5'd9, 16'h0004);
        add9 = r_type(5'd9, 5'd10, 5'd11, 6'h20);
        m_valid = 0; m_mr = 0; m_rs_data = 0; m_rt_data = 0; m_imm = 0; m_pc = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_op = 0; m_funct = 0; m_cnt = 0;

        // Reset held for two cycles.
        rst = 1; id_valid = 0; id_instr = 0; id_pc_plus4 = 0; rf_rd_data1 = 0; rf_rd_data2 = 0;
        wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0; ex_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
        chk("rst_ex_rs_data", ex_rs_data, 32'd0);
        chk("rst_ex_rt_data", ex_rt_data, 32'd0);
        chk("rst_ex_imm", ex_imm, 32'd0);
        chk("rst_ex_pc", ex_pc_plus4, 32'd0);
        chk("rst_ex_opcode", {26'd0, ex_opcode}, 32'd0);
        chk("rst_stall_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_id_stall", {31'd0, id_stall}, 32'd0);

        // Load-use: LW $9 followed by ADD reading $9.
        set_in(0, 1, lw9, 32'h100, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        advance();
        chk("lu_lw_mr", {31'd0, ex_mem_read}, 32'd1);
        set_in(0, 1, add9, 32'h104, 32'h11, 32'h22, 0, 0, 0, 0, 1);
        chk("lu_stall", {31'd0, id_stall}, 32'd1);
        advance();
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        chk("lu_cnt", {28'd0, stall_cnt}, 32'd1);
        set_in(0, 1, add9, 32'h104, 32'h11, 32'h22, 0, 0, 0, 0, 1);
        chk("lu_nostall", {31'd0, id_stall}, 32'd0);
        advance();
        chk("lu_add_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_add_rs", {27'd0, ex_rs}, 32'd9);
        chk("lu_add_rsd", ex_rs_data, 32'h11);

        // Same-cycle writeback to the source register.
        set_in(0, 1, r_type(5'd8, 5'd0, 5'd3, 6'h21), 32'h108, 32'h0, 32'h5, 1, 5'd8,
               32'hCAFE_F00D, 0, 1);
        advance();
`ifdef WB_BYPASS_EN
        chk("bypass_rs", ex_rs_data, 32'hCAFE_F00D);
`else
        chk("bypass_rs", ex_rs_data, 32'h0000_0000);
`endif
        chk("bypass_rt0", ex_rt_data, 32'h0);

        // Execute back-pressure for three cycles holds the entry.
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, i_type(6'h08, 5'd1, 5'd2, 16'h8000), 32'h200 + i, 32'h1, 32'h2,
                   0, 0, 0, 0, 0);
            chk("hold_stall", {31'd0, id_stall}, 32'd1);
            advance();
            chk("hold_pc", ex_pc_plus4, 32'h108);
            chk("hold_valid", {31'd0, ex_valid}, 32'd1);
        end

        // Flush coincident with a load-use hazard; then writeback to $0.
        set_in(0, 1, lw9, 32'h300, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        advance();
        set_in(0, 1, add9, 32'h304, 32'h1, 32'h2, 0, 0, 0, 1, 1);
        chk("fl_hz_stall", {31'd0, id_stall}, 32'd1);
        advance();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_cnt", {28'd0, stall_cnt}, 32'd1);
        set_in(0, 1, i_type(6'h08, 5'd0, 5'd4, 16'hFFFE), 32'h308, 32'h1234_5678, 32'h9,
               1, 5'd0, 32'hDEAD_BEEF, 0, 1);
        advance();
        chk("zero_rs", ex_rs_data, 32'h0);
        chk("zero_imm", ex_imm, 32'hFFFF_FFFE);

        // Drive 2^CNTW+3 load-use pairs; the counter must saturate.
        for (int i = 0; i < (1 << CNTW) + 3; i++) begin
            set_in(0, 1, lw9, 32'h400, 32'h0, 32'h0, 0, 0, 0, 0, 1);
            advance();
            set_in(0, 1, add9, 32'h404, 32'h3, 32'h4, 0, 0, 0, 0, 1);
            advance();
            set_in(0, 1, add9, 32'h404, 32'h3, 32'h4, 0, 0, 0, 0, 1);
            advance();
        end
        chk("sat_cnt", {28'd0, stall_cnt}, 32'h0000_000F);

        // Random traffic over a small register window to make hazards and bypasses frequent.
        for (int i = 0; i < 1500; i++) begin
            instr = i_type(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 16'($urandom));
            set_in(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 85), instr,
                   $urandom, $urandom, $urandom, $urandom_range(0, 1) == 1,
                   5'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 3) != 0));
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
